id_ex_stage_reg: RTL

- Pipeline register between the instruction decode/control stage and the execute stage.
- Latches the decoder's control bundle, operands and register addresses each cycle.
- Detects load-use hazards against the instruction currently in EX; on a hazard it inserts a bubble and stalls fetch/decode.
- Also handles branch flush and a global hold, and keeps a saturating bubble counter.

---
 rtl/id_ex_stage_reg.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_reg
// Description : Register between the ID and EX stages. It latches the decoded
//               control bundle, operands and register fields each cycle. It
//               detects load-use hazards against the instruction in EX, inserts
//               a bubble and stalls IF/ID when one is found. It also handles a
//               branch flush, a global hold and a saturating bubble counter.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, rst_n          - rising-edge clock, asynchronous active-low reset
//   hold                - freeze every registered output (memory not ready)
//   flush               - branch taken in EX; squash the ID instruction
//   id_valid, id_*      - decoded instruction from the ID stage
//   ex_valid, ex_*      - registered copies presented to the EX stage
//   ex_dest             - registered destination (rd for R-type, else rt)
//   stall_id            - combinational; IF/ID register and PC must hold
//   bubble_count        - saturating count of hazard bubbles inserted
// ============================================================================
module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              flush,
    input  logic              id_valid,
    input  logic              id_reg_write,
    input  logic              id_mem_to_reg_write,
    input  logic              id_mem_write,
    input  logic              id_branch,
    input  logic              id_alu_source,
    input  logic              id_alu_source_shift,
    input  logic              id_reg_dst,
    input  logic [3:0]        id_alu_control,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc_plus4,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [4:0]        id_shamt,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_to_reg_write,
    output logic              ex_mem_write,
    output logic              ex_branch,
    output logic              ex_alu_source,
    output logic              ex_alu_source_shift,
    output logic              ex_reg_dst,
    output logic [3:0]        ex_alu_control,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc_plus4,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [4:0]        ex_shamt,
    output logic [4:0]        ex_dest,
    output logic              stall_id,
    output logic [CNT_W-1:0]  bubble_count
);

    localparam logic [4:0]       c_REG_ZERO = 5'd0;
    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

    logic              r_valid;
    logic              r_reg_write;
    logic              r_mem_to_reg_write;
    logic              r_mem_write;
    logic              r_branch;
    logic              r_alu_source;
    logic              r_alu_source_shift;
    logic              r_reg_dst;
    logic [3:0]        r_alu_control;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_pc_plus4;
    logic [4:0]        r_rs;
    logic [4:0]        r_rt;
    logic [4:0]        r_rd;
    logic [4:0]        r_shamt;
    logic [4:0]        r_dest;
    logic [CNT_W-1:0]  r_bubble_count;

    logic w_uses_rs;
    logic w_uses_rt;
    logic w_ex_is_load;
    logic w_hazard;
    logic w_bubble;
    logic w_count_en;

    // Shift instructions take their operand from rt; rs is unused.
    assign w_uses_rs = ~id_alu_source_shift;
    assign w_uses_rt = id_reg_dst | id_branch | id_mem_write;

    // A load writing a non-zero register sits in EX; its data is not ready
    // for a consumer in ID until one cycle later.
    assign w_ex_is_load = r_valid & r_reg_write & r_mem_to_reg_write &
                          (r_dest != c_REG_ZERO);

    assign w_hazard = id_valid & w_ex_is_load &
                      ((w_uses_rs & (id_rs == r_dest)) |
                       (w_uses_rt & (id_rt == r_dest)));

    assign stall_id   = w_hazard & ~flush & ~hold;
    assign w_bubble   = flush | w_hazard;
    // Only hazard bubbles are counted; a flush on the same edge takes over.
    assign w_count_en = w_hazard & ~flush & (r_bubble_count != c_CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid            <= 1'b0;
            r_reg_write        <= 1'b0;
            r_mem_to_reg_write <= 1'b0;
            r_mem_write        <= 1'b0;
            r_branch           <= 1'b0;
            r_alu_source       <= 1'b0;
            r_alu_source_shift <= 1'b0;
            r_reg_dst          <= 1'b0;
            r_alu_control      <= 4'd0;
            r_rs_data          <= '0;
            r_rt_data          <= '0;
            r_imm              <= '0;
            r_pc_plus4         <= '0;
            r_rs               <= 5'd0;
            r_rt               <= 5'd0;
            r_rd               <= 5'd0;
            r_shamt            <= 5'd0;
            r_dest             <= 5'd0;
            r_bubble_count     <= '0;
        end else if (!hold) begin
            // Data and address fields are don't-care inside a bubble, so they
            // load unconditionally and only the control bits are qualified.
            r_alu_source       <= id_alu_source;
            r_alu_source_shift <= id_alu_source_shift;
            r_reg_dst          <= id_reg_dst;
            r_alu_control      <= id_alu_control;
            r_rs_data          <= id_rs_data;
            r_rt_data          <= id_rt_data;
            r_imm              <= id_imm;
            r_pc_plus4         <= id_pc_plus4;
            r_rs               <= id_rs;
            r_rt               <= id_rt;
            r_rd               <= id_rd;
            r_shamt            <= id_shamt;
            r_dest             <= id_reg_dst ? id_rd : id_rt;
            if (w_bubble) begin
                r_valid            <= 1'b0;
                r_reg_write        <= 1'b0;
                r_mem_to_reg_write <= 1'b0;
                r_mem_write        <= 1'b0;
                r_branch           <= 1'b0;
            end else begin
                r_valid            <= id_valid;
                r_reg_write        <= id_reg_write & id_valid;
                r_mem_to_reg_write <= id_mem_to_reg_write;
                r_mem_write        <= id_mem_write & id_valid;
                r_branch           <= id_branch & id_valid;
            end
            if (w_count_en) begin
                r_bubble_count <= r_bubble_count + CNT_W'(1);
            end
        end
    end

    assign ex_valid            = r_valid;
    assign ex_reg_write        = r_reg_write;
    assign ex_mem_to_reg_write = r_mem_to_reg_write;
    assign ex_mem_write        = r_mem_write;
    assign ex_branch           = r_branch;
    assign ex_alu_source       = r_alu_source;
    assign ex_alu_source_shift = r_alu_source_shift;
    assign ex_reg_dst          = r_reg_dst;
    assign ex_alu_control      = r_alu_control;
    assign ex_rs_data          = r_rs_data;
    assign ex_rt_data          = r_rt_data;
    assign ex_imm              = r_imm;
    assign ex_pc_plus4         = r_pc_plus4;
    assign ex_rs               = r_rs;
    assign ex_rt               = r_rt;
    assign ex_rd               = r_rd;
    assign ex_shamt            = r_shamt;
    assign ex_dest             = r_dest;
    assign bubble_count        = r_bubble_count;

endmodule
`default_nettype wire
